// File: rtl/sregn_pipe_vr.sv
// DEPTH-stage valid/ready pipeline register chain with global stall, synchronous
// flush, bubble collapsing and an occupancy count.
module sregn_pipe_vr #(
    parameter int width      = 32,
    parameter int depth      = 4,
    parameter bit reset_data = 1'b1,
    parameter int cnt_w      = $clog2(depth + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] i0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] o0,
    output logic [cnt_w-1:0] count
);

    logic [width-1:0] data_q [depth];
    logic [width-1:0] data_d [depth];
    logic [depth-1:0] v_q;
    logic [depth-1:0] v_d;
    logic [cnt_w-1:0] count_q;
    logic [cnt_w-1:0] count_d;
    logic [depth:0]   rdy;
    logic             run;
    logic             in_fire;
    logic             out_fire;

    // A stage can take new contents if it is empty or its successor is moving.
    always_comb begin
        rdy        = '0;
        rdy[depth] = out_ready;
        for (int unsigned i = 0; i < depth; i++) begin
            rdy[depth-1-i] = !v_q[depth-1-i] | rdy[depth-i];
        end
    end

    always_comb begin
        run       = enable & !flush;
        in_ready  = run & rdy[0] & !reset;
        out_valid = run & v_q[depth-1];
        in_fire   = in_valid & in_ready;
        out_fire  = out_valid & out_ready;
    end

    // Data only moves with a valid item so an emptied output keeps its last value.
    always_comb begin
        v_d = v_q;
        for (int unsigned k = 0; k < depth; k++) begin
            data_d[k] = data_q[k];
        end
        if (flush) begin
            v_d = '0;
        end else if (run) begin
            if (rdy[0]) begin
                v_d[0] = in_fire;
                if (in_fire) begin
                    data_d[0] = i0;
                end
            end
            for (int unsigned k = 1; k < depth; k++) begin
                if (rdy[k]) begin
                    v_d[k] = v_q[k-1];
                    if (v_q[k-1]) begin
                        data_d[k] = data_q[k-1];
                    end
                end
            end
        end
    end

    always_comb begin
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + cnt_w'(in_fire) - cnt_w'(out_fire);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q     <= '0;
            count_q <= '0;
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
        end
    end

    generate
        if (reset_data) begin : g_data_rst
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int unsigned k = 0; k < depth; k++) begin
                        data_q[k] <= '0;
                    end
                end else begin
                    for (int unsigned k = 0; k < depth; k++) begin
                        data_q[k] <= data_d[k];
                    end
                end
            end
        end else begin : g_data_norst
            always_ff @(posedge clk) begin
                for (int unsigned k = 0; k < depth; k++) begin
                    data_q[k] <= data_d[k];
                end
            end
        end
    endgenerate

    assign o0    = data_q[depth-1];
    assign count = count_q;

endmodule
